// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, MIPS funct/ALUOp
// encodings and the controller FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_NOR = 4'd12;
   localparam logic [3:0] OP_ADD = 4'd15;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ILL   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS ALUOp/funct decode into the ALU 4-bit op code plus an
// illegal flag for undecodable requests.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] op,
   output logic       illegal
);

   always_comb begin
      op      = OP_ADD;
      illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: op = OP_ADD;
         ALUOP_SUB: op = OP_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: op = OP_ADD;
               FUNCT_SUB: op = OP_SUB;
               FUNCT_AND: op = OP_AND;
               FUNCT_OR:  op = OP_OR;
               FUNCT_NOR: op = OP_NOR;
               FUNCT_SLT: op = OP_SLT;
               default:   illegal = 1'b1;
            endcase
         end
         ALUOP_ILL: illegal = 1'b1;
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one operation at a time to the 32-bit combinational ALU and returns
// r/zero over a valid/ready handshake. Optional perf counter: ALU_ISSUE_PERF_EN.
//
// state | meaning
// IDLE  | ready for a request; operands/op captured on in_valid
// EXEC  | ALU settling on registered operands; result captured at end
// DONE  | result presented until the consumer takes it
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   aluop,
   input  logic [5:0]   funct,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] alu_x,
   output logic [W-1:0] alu_y,
   output logic [3:0]   alu_op,
   input  logic [W-1:0] alu_r,
   input  logic         alu_zero,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_r,
   output logic         out_zero,
   output logic         out_err
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [15:0]  perf_cnt
`endif
);

   state_e         state_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic [W-1:0]   out_r_q;
   logic           out_zero_q;
   logic           out_err_q;
   logic [W-1:0]   alu_x_q;
   logic [W-1:0]   alu_y_q;
   logic [3:0]     alu_op_q;
   logic [3:0]     dec_op;
   logic           dec_illegal;

   alu_op_decode u_dec (
      .aluop   (aluop),
      .funct   (funct),
      .op      (dec_op),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_r_q     <= '0;
         out_zero_q  <= 1'b0;
         out_err_q   <= 1'b0;
         alu_x_q     <= '0;
         alu_y_q     <= '0;
         alu_op_q    <= OP_ADD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  alu_x_q    <= a;
                  alu_y_q    <= b;
                  in_ready_q <= 1'b0;
                  // Illegal requests keep the previous op so the ALU never sees garbage.
                  if (dec_illegal) begin
                     out_r_q     <= '0;
                     out_zero_q  <= 1'b0;
                     out_err_q   <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     alu_op_q <= dec_op;
                     state_q  <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               out_r_q     <= alu_r;
               out_zero_q  <= alu_zero;
               out_err_q   <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] perf_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_cnt_q <= '0;
      end else if (out_valid_q && out_ready && !out_err_q && perf_cnt_q != 16'hFFFF) begin
         perf_cnt_q <= perf_cnt_q + 16'd1;
      end
   end

   assign perf_cnt = perf_cnt_q;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_r     = out_r_q;
   assign out_zero  = out_zero_q;
   assign out_err   = out_err_q;
   assign alu_x     = alu_x_q;
   assign alu_y     = alu_y_q;
   assign alu_op    = alu_op_q;

endmodule
